// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: oversampled 3-sample majority vote, LSB-first
// deserialiser, start/data/parity/stop sequencing and parity checker handshake.
module uart_rx_frame_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_err,
  output logic [7:0]            p_data,
  output logic                  sampled_bit,
  output logic                  data_sampled,
  output logic                  par_check_en,
  output logic                  data_valid,
  output logic                  stop_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [PRESCALE_W-1:0] edge_cnt_r;
  logic [PRESCALE_W-1:0] presc_r;
  logic [PRESCALE_W-1:0] half_s;
  logic [2:0]            bit_cnt_r;
  logic                  par_en_r;
  logic                  par_bad_r;
  logic                  smp0_r;
  logic                  smp1_r;
  logic                  last_edge_s;
  logic                  smp_a_s;
  logic                  smp_b_s;
  logic                  smp_c_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign half_s       = presc_r >> 1;
  assign last_edge_s  = (edge_cnt_r == (presc_r - PRESCALE_W'(1)));
  assign smp_a_s      = (edge_cnt_r == (half_s - PRESCALE_W'(1)));
  assign smp_b_s      = (edge_cnt_r == half_s);
  assign smp_c_s      = (edge_cnt_r == (half_s + PRESCALE_W'(1)));
  assign busy         = (state_r != ST_IDLE);
  assign par_check_en = (state_r == ST_PARITY);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_in) state_nxt_s = ST_START;
        else        state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (data_sampled && sampled_bit) state_nxt_s = ST_IDLE;
        else if (last_edge_s)            state_nxt_s = ST_DATA;
        else                             state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (last_edge_s && (bit_cnt_r == 3'd7)) state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
        else                                    state_nxt_s = ST_DATA;
      end
      ST_PARITY: begin
        if (last_edge_s) state_nxt_s = ST_STOP;
        else             state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (last_edge_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bit timing, majority sampling, shift register and frame status.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_r   <= {PRESCALE_W{1'b0}};
      bit_cnt_r    <= 3'd0;
      presc_r      <= PRESCALE_W'(8);
      par_en_r     <= 1'b0;
      par_bad_r    <= 1'b0;
      smp0_r       <= 1'b1;
      smp1_r       <= 1'b1;
      p_data       <= 8'h00;
      sampled_bit  <= 1'b1;
      data_sampled <= 1'b0;
      data_valid   <= 1'b0;
      stop_err     <= 1'b0;
    end else begin
      data_sampled <= 1'b0;
      data_valid   <= 1'b0;
      if (state_r == ST_IDLE) begin
        edge_cnt_r <= {PRESCALE_W{1'b0}};
        bit_cnt_r  <= 3'd0;
        // Frame configuration is frozen for the whole frame.
        if (!rx_in) begin
          presc_r   <= prescale;
          par_en_r  <= par_en;
          par_bad_r <= 1'b0;
        end
      end else begin
        if (last_edge_s || (state_nxt_s == ST_IDLE)) edge_cnt_r <= {PRESCALE_W{1'b0}};
        else                                         edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
        if (smp_a_s) smp0_r <= rx_in;
        if (smp_b_s) smp1_r <= rx_in;
        if (smp_c_s) sampled_bit <= maj3(smp0_r, smp1_r, rx_in);
        data_sampled <= smp_c_s;
        if (data_sampled && (state_r == ST_DATA)) p_data <= {sampled_bit, p_data[7:1]};
        if (data_sampled && (state_r == ST_STOP)) stop_err <= ~sampled_bit;
        if (last_edge_s && (state_r == ST_DATA)) bit_cnt_r <= bit_cnt_r + 3'd1;
        // Checker result has settled by the end of the parity bit.
        if (last_edge_s && (state_r == ST_PARITY)) par_bad_r <= par_err;
        if (last_edge_s && (state_r == ST_STOP)) data_valid <= ~stop_err & ~(par_en_r & par_bad_r);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl with a behavioural even/odd parity
// checker closing the par_check_en/par_err loop.
module tb_uart_rx_frame_ctrl;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_err;
  logic [7:0]    p_data;
  logic          sampled_bit;
  logic          data_sampled;
  logic          par_check_en;
  logic          data_valid;
  logic          stop_err;
  logic          busy;
  logic          par_type = 1'b0;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          ds_cnt = 0;
  int          ov_cnt = 0;
  int          pce_cnt = 0;
  int          dv_cnt = 0;

  uart_rx_frame_ctrl #(.PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .par_err(par_err), .p_data(p_data), .sampled_bit(sampled_bit),
    .data_sampled(data_sampled), .par_check_en(par_check_en),
    .data_valid(data_valid), .stop_err(stop_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream parity checker: registered result one cycle after the parity strobe.
  always @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else if (data_sampled && par_check_en) par_err <= (^p_data) ^ sampled_bit ^ par_type;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: strobe counters and scoreboard pop on data_valid.
  always @(negedge clk) begin
    if (data_sampled) ds_cnt <= ds_cnt + 1;
    if (par_check_en) pce_cnt <= pce_cnt + 1;
    if (data_sampled && par_check_en) ov_cnt <= ov_cnt + 1;
    if (data_valid) begin
      dv_cnt <= dv_cnt + 1;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_data", {24'd0, p_data}, {24'd0, mon_e.data});
        chk("valid_cycle", cyc + 1, mon_e.at);
        chk("busy_at_valid", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_p_data"}, {24'd0, p_data}, 32'h00);
    chk({tag, "_sampled_bit"}, {31'd0, sampled_bit}, 32'd1);
    chk({tag, "_data_sampled"}, {31'd0, data_sampled}, 32'd0);
    chk({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
    chk({tag, "_stop_err"}, {31'd0, stop_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_par_check_en"}, {31'd0, par_check_en}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Drives one frame, each bit held for p cycles, followed by one idle-high cycle.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic par_bit, input logic stop_bit, input logic ok,
                            input int abort_bit, input logic disturb);
    logic [10:0] bits;
    int          n;
    int unsigned t0;
    exp_t        e;
    n = pe ? 11 : 10;
    if (pe) bits = {stop_bit, par_bit, d, 1'b0};
    else    bits = {1'b1, stop_bit, d, 1'b0};
    @(negedge clk);
    prescale = PW'(p);
    par_en   = pe;
    t0       = cyc + 1;
    if (ok) begin
      e.data = d;
      e.at   = t0 + n * p + 1;
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < p; j++) begin
        if (k > 0 || j > 0) @(negedge clk);
        rx_in = bits[k];
        if (disturb && k == 1 && j == 0) begin
          prescale = (p == 16) ? PW'(8) : PW'(16);
          par_en   = ~pe;
        end
        if (k == abort_bit && j == p / 2) begin
          rx_in = 1'b1;
          rst   = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    rx_in    = 1'b1;
    prescale = PW'(p);
    par_en   = pe;
  endtask

  initial begin
    int          ds0, ov0, pce0, dv0;
    int unsigned t0;
    rst = 1'b1; rx_in = 1'b1; prescale = PW'(8); par_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    idle(3);

    // P=8 with parity, 0xA5 (even parity bit 0).
    ds0 = ds_cnt; ov0 = ov_cnt; pce0 = pce_cnt;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    chk("a5_p_data", {24'd0, p_data}, 32'hA5);
    chk("a5_stop_err", {31'd0, stop_err}, 32'd0);
    chk("a5_strobes", ds_cnt - ds0, 32'd11);
    chk("a5_overlap", ov_cnt - ov0, 32'd1);
    chk("a5_pce_cycles", pce_cnt - pce0, 32'd8);
    chk("a5_sb_empty", sb.size(), 32'd0);

    // P=16 no parity, config inputs disturbed mid-frame.
    ds0 = ds_cnt; pce0 = pce_cnt;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    idle(4);
    chk("3c_p_data", {24'd0, p_data}, 32'h3C);
    chk("3c_strobes", ds_cnt - ds0, 32'd10);
    chk("3c_pce_cycles", pce_cnt - pce0, 32'd0);
    chk("3c_sb_empty", sb.size(), 32'd0);

    // Start glitch: low for two cycles at P=8.
    ds0 = ds_cnt; dv0 = dv_cnt;
    @(negedge clk);
    prescale = PW'(8); par_en = 1'b0; rx_in = 1'b0;
    t0 = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    rx_in = 1'b1;
    while (cyc + 1 < t0 + 7) @(negedge clk);
    chk("glitch_busy_before", {31'd0, busy}, 32'd1);
    chk("glitch_strobe", {31'd0, data_sampled}, 32'd1);
    @(negedge clk);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    idle(4);
    chk("glitch_p_data", {24'd0, p_data}, 32'h3C);
    chk("glitch_no_valid", dv_cnt - dv0, 32'd0);
    chk("glitch_strobes", ds_cnt - ds0, 32'd1);

    // Bad stop bit, then a good frame clears stop_err.
    dv0 = dv_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    idle(4);
    chk("stop_err_set", {31'd0, stop_err}, 32'd1);
    chk("stop_p_data", {24'd0, p_data}, 32'h55);
    chk("stop_no_valid", dv_cnt - dv0, 32'd0);
    send_frame(8'h69, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    chk("stop_err_clr", {31'd0, stop_err}, 32'd0);
    chk("69_valid", dv_cnt - dv0, 32'd1);

    // Wrong parity bit: 0x01 needs parity 1 under even parity.
    dv0 = dv_cnt;
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    idle(4);
    chk("par_no_valid", dv_cnt - dv0, 32'd0);
    chk("par_p_data", {24'd0, p_data}, 32'h01);

    // par_err still high but parity disabled: frame accepted, P=32.
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    chk("c3_p_data", {24'd0, p_data}, 32'hC3);
    chk("c3_valid", dv_cnt - dv0, 32'd1);

    // Back-to-back, reset during second frame's bit 3, then a clean third frame.
    dv0 = dv_cnt;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    chk_reset("abort");
    idle(4);
    chk("b2b_valids", dv_cnt - dv0, 32'd1);
    chk("b2b_sb_empty", sb.size(), 32'd0);
    send_frame(8'h56, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    chk("56_p_data", {24'd0, p_data}, 32'h56);
    chk("56_valid", dv_cnt - dv0, 32'd2);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller for the UART RX path. It oversamples the serial line, takes a 3-sample majority vote per bit and deserialises 8 data bits LSB-first. It sequences start, data, parity and stop bits and drives the enable/strobe interface of the downstream parity checker. It consumes that checker's `par_err` and issues a one-cycle `data_valid` for every clean frame.

## Interface
- `PRESCALE_W`, 6: width of the `prescale` input.
- `clk`  in  1  system clock, oversampling clock (prescale × baud).
- `rst`  in  1  synchronous, active-high reset.
- `rx_in`  in  1  serial line; idle high.
- `prescale`  in  `PRESCALE_W`  clocks per bit (P); legal values 8, 16, 32.
- `par_en`  in  1  frame carries a parity bit.
- `par_err`  in  1  registered result from the parity checker.
- `p_data`  out  8  deserialised byte.
- `sampled_bit`  out  1  majority value of the current bit.
- `data_sampled`  out  1  one-cycle strobe; `sampled_bit` is valid.
- `par_check_en`  out  1  high while in the PARITY state.
- `data_valid`  out  1  one-cycle pulse when the frame is good.
- `stop_err`  out  1  the last stop bit sampled low.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Reset values: state IDLE; `edge_cnt` 0; `bit_cnt` 0; `p_data` 0x00; `sampled_bit` 1; `data_sampled` 0; `data_valid` 0; `stop_err` 0. Derived outputs `par_check_en` and `busy` are 0.
- `edge_cnt` counts 0..P-1 within each bit and wraps to 0 on every bit boundary.
- Majority sampling: raw `rx_in` is captured at `edge_cnt` = P/2-1, P/2 and P/2+1.
  - At `edge_cnt` = P/2+1 the vote (≥2 ones → 1) is registered into `sampled_bit`.
  - `data_sampled` pulses in the next cycle (`edge_cnt` = P/2+2).
- `prescale` and `par_en` are latched on the IDLE→START transition. Changes mid-frame have no effect.
- States:
  - IDLE: `rx_in`=0 → START with `edge_cnt`=0.
  - START: on `data_sampled` with `sampled_bit`=1 (glitch) → IDLE. Otherwise, at `edge_cnt`=P-1 → DATA with `bit_cnt`=0.
  - DATA: on `data_sampled`, `p_data` ← {`sampled_bit`, `p_data`[7:1]}. At `edge_cnt`=P-1, `bit_cnt` increments. After bit 7: → PARITY if latched `par_en`, else → STOP.
  - PARITY: `par_check_en`=1. The checker updates `par_err` the cycle after `data_sampled`. At `edge_cnt`=P-1 → STOP.
  - STOP: on `data_sampled`, `stop_err` ← ~`sampled_bit`. At `edge_cnt`=P-1 → IDLE.
    - `data_valid` is registered high for one cycle iff the stop bit sampled 1 and not (latched `par_en` && `par_err`).
- `p_data` holds its value from the end of the frame until the next frame's first data strobe.
- `stop_err` holds until the next frame's stop-bit strobe or reset.
- `par_err` is ignored when latched `par_en`=0.
- Reset while in any state is synchronous: next cycle is IDLE with all reset values. No `data_valid` is issued for the aborted frame.
- `rx_in` low in the cycle IDLE is re-entered starts the next frame immediately (back-to-back frames).

## Timing
- Let t0 be the clock edge where IDLE sees `rx_in`=0.
  - START begins at t0+1.
  - Bit k (start = 0) occupies cycles t0+1+k·P .. t0+(k+1)·P.
- `data_valid` is high exactly at cycle t0+N·P+1, with N=10 (no parity) or 11 (parity). `busy` drops in the same cycle.
- Glitch abort: IDLE at t0+P/2+4. `data_valid` is not asserted.
- `data_sampled` asserts once per bit, including start, parity and stop: 10 or 11 pulses per frame.
- `par_check_en` and `data_sampled` overlap for exactly one cycle per parity frame.
- No combinational path from `rx_in` to any output.

## Test plan
- P=8, `par_en`=1, checker `par_type`=0, frame 0xA5 + parity 0 + stop 1: `p_data`=0xA5; `data_valid` pulses once at t0+89; `stop_err`=0; 11 `data_sampled` strobes.
- P=16, `par_en`=0, frame 0x3C: `data_valid` at t0+161; `p_data`=0x3C; `par_check_en` never asserted.
- Start glitch: `rx_in` low for 2 cycles then high, P=8: return to IDLE; `p_data` unchanged; no `data_valid`.
- Stop bit driven 0, P=8, 0x55: `stop_err`=1; no `data_valid`. The next good frame clears `stop_err` and pulses `data_valid`.
- Parity bit wrong (0x01 with parity 0, `par_type`=0): checker raises `par_err`; no `data_valid`; `p_data`=0x01.
- Two back-to-back frames 0x12, 0x34 with `rst` pulsed during the second frame's bit 3: `data_valid` only for 0x12; outputs return to reset values; a third frame 0x56 is received correctly.
